// File: rtl/regfile_write_scheduler.sv
// Register file write-port arbiter: an init sweep zeroes x1..x31, then writeback and
// debug requests share the port with WB priority and a starvation guard for debug.
module regfile_write_scheduler #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  input  logic              dbg_valid_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_data_i,
  output logic              dbg_ready_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_enable_o,
  output logic              init_done_o
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        StarveMax = 4'(STARVE_LIMIT);

  state_e            r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [3:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_enable;
  logic              r_init_done;

  logic w_wb_ready;
  logic w_dbg_ready;
  logic w_force_dbg;

  // Grant is combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    w_wb_ready  = 1'b0;
    w_dbg_ready = 1'b0;
    w_force_dbg = (r_starve_cnt == StarveMax);
    if (r_state == StRun && !clear_i) begin
      if (dbg_valid_i && (w_force_dbg || !wb_valid_i)) begin
        w_dbg_ready = 1'b1;
      end else if (wb_valid_i) begin
        w_wb_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StInit;
      r_init_cnt   <= ADDR_W'(1);
      r_starve_cnt <= 4'd0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_enable  <= 1'b0;
      r_init_done  <= 1'b0;
    end else if (clear_i) begin
      r_state      <= StInit;
      r_init_cnt   <= ADDR_W'(1);
      r_starve_cnt <= 4'd0;
      r_wr_enable  <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      case (r_state)
        StInit: begin
          r_wr_addr   <= r_init_cnt;
          r_wr_data   <= '0;
          r_wr_enable <= 1'b1;
          if (r_init_cnt == LastAddr) begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + ADDR_W'(1);
          end
        end
        StRun: begin
          if (w_dbg_ready) begin
            r_wr_addr   <= dbg_addr_i;
            r_wr_data   <= dbg_data_i;
            r_wr_enable <= |dbg_addr_i;
          end else if (w_wb_ready) begin
            r_wr_addr   <= wb_addr_i;
            r_wr_data   <= wb_data_i;
            r_wr_enable <= |wb_addr_i;
          end else begin
            r_wr_enable <= 1'b0;
          end
          // Losses only accumulate while DBG keeps asking; saturate at the limit.
          if (w_dbg_ready || !dbg_valid_i) begin
            r_starve_cnt <= 4'd0;
          end else if (r_starve_cnt < StarveMax) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign wb_ready_o  = w_wb_ready;
  assign dbg_ready_o = w_dbg_ready;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign wr_enable_o = r_wr_enable;
  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: sweep, arbitration, starvation, x0, clear, reset.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_i;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ready_o;
  logic        dbg_valid_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_i;
  logic        dbg_ready_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        wr_enable_o;
  logic        init_done_o;

  int total = 0;
  int bad   = 0;

  regfile_write_scheduler #(
    .NUM_REGS    (32),
    .ADDR_W      (5),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear_i),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .wb_ready_o (wb_ready_o),
    .dbg_valid_i(dbg_valid_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_i (dbg_data_i),
    .dbg_ready_o(dbg_ready_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_enable_o(wr_enable_o),
    .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        dv;
    logic [4:0]  da;
    logic [31:0] dd;
    logic        e_wr;
    logic        e_dr;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_done;
  } vec_t;

  function automatic vec_t mk(input logic clr, input logic wv, input logic [4:0] wa,
                              input logic [31:0] wd, input logic dv, input logic [4:0] da,
                              input logic [31:0] dd, input logic e_wr, input logic e_dr,
                              input logic e_en, input logic [4:0] e_addr,
                              input logic [31:0] e_data, input logic e_done);
    vec_t v;
    v.clr = clr; v.wv = wv; v.wa = wa; v.wd = wd; v.dv = dv; v.da = da; v.dd = dd;
    v.e_wr = e_wr; v.e_dr = e_dr; v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives, checks grants, clocks, checks registered outputs.
  task automatic apply(input vec_t v, input string nm);
    clear_i     = v.clr;
    wb_valid_i  = v.wv;
    wb_addr_i   = v.wa;
    wb_data_i   = v.wd;
    dbg_valid_i = v.dv;
    dbg_addr_i  = v.da;
    dbg_data_i  = v.dd;
    #1;
    chk({nm, " wb_ready"}, 32'(wb_ready_o), 32'(v.e_wr));
    chk({nm, " dbg_ready"}, 32'(dbg_ready_o), 32'(v.e_dr));
    @(posedge clk);
    #1;
    chk({nm, " en"}, 32'(wr_enable_o), 32'(v.e_en));
    chk({nm, " addr"}, 32'(wr_addr_o), 32'(v.e_addr));
    chk({nm, " data"}, wr_data_o, v.e_data);
    chk({nm, " done"}, 32'(init_done_o), 32'(v.e_done));
    @(negedge clk);
  endtask

  task automatic sweep(input string tag, input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd, input int last);
    for (int i = 1; i <= last; i++) begin
      apply(mk(1'b0, wv, wa, wd, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'(i), 32'd0, i == 31),
            $sformatf("%s[%0d]", tag, i));
    end
  endtask

  vec_t run_tbl[21];

  initial begin
    // Index: {clr, wv, wa, wd, dv, da, dd, e_wr, e_dr, e_en, e_addr, e_data, e_done}
    run_tbl[0]  = mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 1);
    run_tbl[1]  = mk(0, 0, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0, 0, 0, 5'd5, 32'hDEADBEEF, 1);
    run_tbl[2]  = mk(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hA5A5, 0, 1, 1, 5'd7, 32'hA5A5, 1);
    run_tbl[3]  = mk(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'h22, 1, 0, 1, 5'd3, 32'h11, 1);
    run_tbl[4]  = mk(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1, 0, 5'd0, 32'h1234, 1);
    run_tbl[5]  = mk(0, 1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 1, 0, 0, 5'd0, 32'h55, 1);
    run_tbl[6]  = mk(0, 1, 5'd31, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd31, 32'hFFFFFFFF, 1);
    for (int k = 0; k < 4; k++) begin
      run_tbl[7+k] = mk(0, 1, 5'd1, 32'h101 + 32'(k), 1, 5'd2, 32'hBB, 1, 0, 1, 5'd1,
                        32'h101 + 32'(k), 1);
    end
    run_tbl[11] = mk(0, 1, 5'd1, 32'h105, 1, 5'd2, 32'hBB, 0, 1, 1, 5'd2, 32'hBB, 1);
    run_tbl[12] = mk(0, 1, 5'd1, 32'h106, 0, 5'd0, 32'h0, 1, 0, 1, 5'd1, 32'h106, 1);
    run_tbl[13] = mk(0, 1, 5'd4, 32'h40, 1, 5'd2, 32'hCC, 1, 0, 1, 5'd4, 32'h40, 1);
    run_tbl[14] = mk(0, 1, 5'd4, 32'h41, 1, 5'd2, 32'hCC, 1, 0, 1, 5'd4, 32'h41, 1);
    run_tbl[15] = mk(0, 1, 5'd4, 32'h42, 0, 5'd0, 32'h0, 1, 0, 1, 5'd4, 32'h42, 1);
    for (int k = 0; k < 4; k++) begin
      run_tbl[16+k] = mk(0, 1, 5'd8, 32'h80 + 32'(k), 1, 5'd2, 32'hBB, 1, 0, 1, 5'd8,
                         32'h80 + 32'(k), 1);
    end
    run_tbl[20] = mk(0, 1, 5'd8, 32'h84, 1, 5'd2, 32'hBB, 0, 1, 1, 5'd2, 32'hBB, 1);

    reset = 1'b1; clear_i = 1'b0;
    wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    dbg_valid_i = 1'b0; dbg_addr_i = '0; dbg_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset en", 32'(wr_enable_o), 32'd0);
    chk("reset addr", 32'(wr_addr_o), 32'd0);
    chk("reset data", wr_data_o, 32'd0);
    chk("reset done", 32'(init_done_o), 32'd0);
    chk("reset wb_ready", 32'(wb_ready_o), 32'd0);
    chk("reset dbg_ready", 32'(dbg_ready_o), 32'd0);
    reset = 1'b0;

    sweep("sweep0", 1'b0, 5'd0, 32'd0, 31);

    for (int i = 0; i < 21; i++) apply(run_tbl[i], $sformatf("run[%0d]", i));

    // Clear with WB pending: WB holds through the whole sweep, then issues.
    apply(mk(1, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 0, 0, 5'd2, 32'hBB, 0), "clear");
    sweep("sweep1", 1'b1, 5'd6, 32'h66, 31);
    apply(mk(0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 0, 1, 5'd6, 32'h66, 1), "post_clear_wb");

    // Reset in the middle of a sweep.
    apply(mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd6, 32'h66, 0), "clear2");
    sweep("sweep2", 1'b0, 5'd0, 32'd0, 17);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset en", 32'(wr_enable_o), 32'd0);
    chk("midreset addr", 32'(wr_addr_o), 32'd0);
    chk("midreset data", wr_data_o, 32'd0);
    chk("midreset done", 32'(init_done_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sweep("sweep3", 1'b0, 5'd0, 32'd0, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
